// File: rtl/cube_state_engine.sv
// cube_state_engine: 54-sticker Rubik's cube state register.
// Moves from the move source are executed as one clockwise quarter turn per cycle.
// The state is exported to the renderer as six 27-bit face buses.
module cube_state_engine (
  input  logic        clk,
  input  logic        resetn,
  input  logic        move_valid,
  output logic        move_ready,
  input  logic [2:0]  move_face,
  input  logic [1:0]  move_dir,
  input  logic        load_solved,
  output logic        done,
  output logic        err,
  output logic        busy,
  output logic [15:0] move_count,
  output logic [26:0] f1,
  output logic [26:0] f2,
  output logic [26:0] f3,
  output logic [26:0] f4,
  output logic [26:0] f5,
  output logic [26:0] f6
);

  typedef enum logic [1:0] {IDLE, TURN, DONE} state_t;

  // Sticker s of the flat cube is face (s / 9), index (s % 9).
  // Face order is F, B, L, R, U, D, so the face base offsets are 0, 9, 18, 27, 36 and 45.
  // The solved state, with face D in the most significant 27 bits.
  localparam logic [53:0][2:0] SOLVED = {
    27'o111111111, 27'o000000000, 27'o444444444,
    27'o555555555, 27'o222222222, 27'o333333333
  };

  // Each face's ring of 12 neighbouring stickers, listed clockwise and given as flat sticker numbers.
  localparam logic [5:0] RING [6][12] = '{
    '{6'd42, 6'd43, 6'd44, 6'd27, 6'd30, 6'd33, 6'd47, 6'd46, 6'd45, 6'd26, 6'd23, 6'd20},
    '{6'd38, 6'd37, 6'd36, 6'd18, 6'd21, 6'd24, 6'd51, 6'd52, 6'd53, 6'd35, 6'd32, 6'd29},
    '{6'd36, 6'd39, 6'd42, 6'd0,  6'd3,  6'd6,  6'd45, 6'd48, 6'd51, 6'd17, 6'd14, 6'd11},
    '{6'd44, 6'd41, 6'd38, 6'd9,  6'd12, 6'd15, 6'd53, 6'd50, 6'd47, 6'd8,  6'd5,  6'd2},
    '{6'd11, 6'd10, 6'd9,  6'd29, 6'd28, 6'd27, 6'd2,  6'd1,  6'd0,  6'd20, 6'd19, 6'd18},
    '{6'd6,  6'd7,  6'd8,  6'd33, 6'd34, 6'd35, 6'd15, 6'd16, 6'd17, 6'd24, 6'd25, 6'd26}
  };

  // Source index of each of the face's own stickers after a clockwise turn.
  localparam logic [3:0] OWN_SRC [9] = '{4'd6, 4'd3, 4'd0, 4'd7, 4'd4, 4'd1, 4'd8, 4'd5, 4'd2};

  logic [53:0][2:0]       cube_reg;
  logic [5:0][53:0][2:0]  turned_all;

  state_t      state_reg, state_next;
  logic [2:0]  face_reg, face_next;
  logic [1:0]  rem_reg, rem_next;
  logic        err_reg, err_next;
  logic [15:0] count_reg, count_next;

  // Precompute one quarter-turn result per face; the FSM selects the latched face.
  for (genvar gi = 0; gi < 6; gi++) begin : g_turn
    logic [53:0][2:0] nxt;

    // Rotate the face's own 3x3 block, then shift its ring by three positions.
    always_comb begin
      nxt = cube_reg;
      for (int i = 0; i < 9; i++) begin
        nxt[6'(gi * 9 + i)] = cube_reg[6'(gi * 9 + int'(OWN_SRC[4'(i)]))];
      end
      for (int q = 0; q < 12; q++) begin
        nxt[RING[gi][4'(q)]] = cube_reg[RING[gi][4'((q + 9) % 12)]];
      end
    end

    assign turned_all[gi] = nxt;
  end

  // Cube storage: reload on reset or load_solved, apply one turn per TURN cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cube_reg <= SOLVED;
    end else if (state_reg == IDLE && load_solved) begin
      cube_reg <= SOLVED;
    end else if (state_reg == TURN) begin
      cube_reg <= turned_all[face_reg];
    end
  end

  // FSM and move bookkeeping registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
      face_reg  <= 3'd0;
      rem_reg   <= 2'd0;
      err_reg   <= 1'b0;
      count_reg <= 16'd0;
    end else begin
      state_reg <= state_next;
      face_reg  <= face_next;
      rem_reg   <= rem_next;
      err_reg   <= err_next;
      count_reg <= count_next;
    end
  end

  // Next-state logic. load_solved has priority over a move request in IDLE.
  always_comb begin
    state_next = state_reg;
    face_next  = face_reg;
    rem_next   = rem_reg;
    err_next   = err_reg;
    count_next = count_reg;
    case (state_reg)
      IDLE: begin
        if (load_solved) begin
          state_next = IDLE;
        end else if (move_valid) begin
          if (move_face > 3'd5 || move_dir == 2'd3) begin
            err_next   = 1'b1;
            state_next = DONE;
          end else begin
            err_next   = 1'b0;
            face_next  = move_face;
            // A prime move is three clockwise turns and a half move is two.
            case (move_dir)
              2'd0:    rem_next = 2'd1;
              2'd1:    rem_next = 2'd3;
              default: rem_next = 2'd2;
            endcase
            state_next = TURN;
          end
        end
      end
      TURN: begin
        rem_next = rem_reg - 2'd1;
        if (rem_reg == 2'd1) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
        if (!err_reg) begin
          count_next = count_reg + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign move_ready = (state_reg == IDLE);
  assign busy       = ~move_ready;
  assign done       = (state_reg == DONE);
  assign err        = done & err_reg;
  assign move_count = count_reg;

  assign f1 = cube_reg[8:0];
  assign f2 = cube_reg[17:9];
  assign f3 = cube_reg[26:18];
  assign f4 = cube_reg[35:27];
  assign f5 = cube_reg[44:36];
  assign f6 = cube_reg[53:45];

endmodule

// File: tb/tb_cube_state_engine.sv
// Directed testbench for cube_state_engine.
// The expected face values are computed by hand from the ring and sticker tables.
module tb_cube_state_engine;

  logic        clk = 1'b0;
  logic        resetn;
  logic        move_valid;
  logic        move_ready;
  logic [2:0]  move_face;
  logic [1:0]  move_dir;
  logic        load_solved;
  logic        done;
  logic        err;
  logic        busy;
  logic [15:0] move_count;
  logic [26:0] f1, f2, f3, f4, f5, f6;

  int checks = 0;
  int errors = 0;

  localparam logic [26:0] S_F = 27'o333333333;
  localparam logic [26:0] S_B = 27'o222222222;
  localparam logic [26:0] S_L = 27'o555555555;
  localparam logic [26:0] S_R = 27'o444444444;
  localparam logic [26:0] S_U = 27'o000000000;
  localparam logic [26:0] S_D = 27'o111111111;

  cube_state_engine dut (
    .clk         (clk),
    .resetn      (resetn),
    .move_valid  (move_valid),
    .move_ready  (move_ready),
    .move_face   (move_face),
    .move_dir    (move_dir),
    .load_solved (load_solved),
    .done        (done),
    .err         (err),
    .busy        (busy),
    .move_count  (move_count),
    .f1          (f1),
    .f2          (f2),
    .f3          (f3),
    .f4          (f4),
    .f5          (f5),
    .f6          (f6)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 'o%0o expected 'o%0o", tag, got, exp);
    end
  endtask

  task automatic check_solved(input string tag);
    check_eq({tag, "_f1"}, f1, S_F);
    check_eq({tag, "_f2"}, f2, S_B);
    check_eq({tag, "_f3"}, f3, S_L);
    check_eq({tag, "_f4"}, f4, S_R);
    check_eq({tag, "_f5"}, f5, S_U);
    check_eq({tag, "_f6"}, f6, S_D);
  endtask

  // Issue one move and hold move_valid until done is seen.
  // exp_lat is the number of edges after acceptance before done; a negative value means "at most 1".
  task automatic do_move(input string tag, input logic [2:0] face, input logic [1:0] dir,
                         input int exp_lat, input logic exp_err);
    int guard;
    int k;
    guard = 0;
    while (!move_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check_eq({tag, "_ready"}, move_ready, 1);
    move_valid = 1'b1;
    move_face  = face;
    move_dir   = dir;
    @(posedge clk); #1;
    check_eq({tag, "_busy"}, busy, 1);
    k = 0;
    while (!done && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    if (exp_lat < 0) check_eq({tag, "_lat_le1"}, (k <= 1 && done), 1);
    else             check_eq({tag, "_lat"}, k, exp_lat);
    check_eq({tag, "_err"}, err, exp_err);
    move_valid = 1'b0;
    @(posedge clk); #1;
    check_eq({tag, "_done_clear"}, done, 0);
    check_eq({tag, "_ready_back"}, move_ready, 1);
    $display("move %s face=%0d dir=%0d latency=%0d err=%0b count=%0d", tag, face, dir, k, exp_err, move_count);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn      = 1'b0;
    move_valid  = 1'b0;
    load_solved = 1'b0;
    move_face   = 3'd0;
    move_dir    = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // Reset state
    check_solved("reset");
    check_eq("reset_count", move_count, 0);
    check_eq("reset_ready", move_ready, 1);
    check_eq("reset_done", done, 0);
    check_eq("reset_err", err, 0);
    check_eq("reset_busy", busy, 0);

    // U clockwise from solved
    do_move("U", 3'd4, 2'd0, 1, 1'b0);
    check_eq("U_f1", f1, 27'o333333444);
    check_eq("U_f2", f2, 27'o222222555);
    check_eq("U_f3", f3, 27'o555555333);
    check_eq("U_f4", f4, 27'o444444222);
    check_eq("U_f5", f5, S_U);
    check_eq("U_f6", f6, S_D);
    check_eq("U_count", move_count, 1);

    // load_solved in IDLE restores the cube without a done pulse
    load_solved = 1'b1;
    @(posedge clk); #1;
    load_solved = 1'b0;
    check_eq("load_done", done, 0);
    check_eq("load_ready", move_ready, 1);
    check_solved("load");
    check_eq("load_count", move_count, 1);
    $display("load_solved count=%0d", move_count);

    // F clockwise, then F counter-clockwise back to solved
    do_move("F", 3'd0, 2'd0, 1, 1'b0);
    check_eq("F_f5", f5, 27'o555000000);
    check_eq("F_f6", f6, 27'o111111444);
    check_eq("F_f3", f3, 27'o155155155);
    check_eq("F_f4", f4, 27'o440440440);
    check_eq("F_count", move_count, 2);
    do_move("Fp", 3'd0, 2'd1, 3, 1'b0);
    check_solved("Fp");
    check_eq("Fp_count", move_count, 3);

    // Illegal face and illegal direction
    do_move("bad_face", 3'd6, 2'd0, -1, 1'b1);
    check_solved("bad_face");
    check_eq("bad_face_count", move_count, 3);
    do_move("bad_dir", 3'd3, 2'd3, -1, 1'b1);
    check_solved("bad_dir");
    check_eq("bad_dir_count", move_count, 3);

    // U2 twice; move_valid stays high through TURN
    do_move("U2a", 3'd4, 2'd2, 2, 1'b0);
    check_eq("U2_f1", f1, 27'o333333222);
    check_eq("U2_f2", f2, 27'o222222333);
    check_eq("U2_f3", f3, 27'o555555444);
    check_eq("U2_f4", f4, 27'o444444555);
    check_eq("U2a_count", move_count, 4);
    do_move("U2b", 3'd4, 2'd2, 2, 1'b0);
    check_solved("U2b");
    check_eq("U2b_count", move_count, 5);

    // (R U R' U') x 6 is the identity
    for (int i = 0; i < 6; i++) begin
      do_move("sexy_R", 3'd3, 2'd0, 1, 1'b0);
      if (i == 0) check_eq("R_f5", f5, 27'o300300300);
      do_move("sexy_U", 3'd4, 2'd0, 1, 1'b0);
      do_move("sexy_Rp", 3'd3, 2'd1, 3, 1'b0);
      do_move("sexy_Up", 3'd4, 2'd1, 3, 1'b0);
    end
    check_solved("sexy6");
    check_eq("sexy6_count", move_count, 29);

    // Reset in the middle of an R' move
    move_valid = 1'b1;
    move_face  = 3'd3;
    move_dir   = 2'd1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("Rp_mid_f5", f5, 27'o300300300);
    check_eq("Rp_mid_busy", busy, 1);
    resetn     = 1'b0;
    move_valid = 1'b0;
    #1;
    check_solved("midreset");
    check_eq("midreset_ready", move_ready, 1);
    check_eq("midreset_done", done, 0);
    check_eq("midreset_count", move_count, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    check_eq("postreset_done", done, 0);
    check_eq("postreset_ready", move_ready, 1);
    check_solved("postreset");
    $display("reset during R' count=%0d ready=%0b", move_count, move_ready);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
